// File: rtl/hpi_txn_sequencer_if.sv
// hpi_txn_sequencer_if
// Request/response handshake bundle between the two HPI requesters and the
// sequencer.
//   req0_* : requester 0 (NIOS PIO path)  valid/ready/write/addr/wdata
//   req1_* : requester 1 (USB poller)     valid/ready/write/addr/wdata
//   rsp_*  : one-cycle completion pulse with owner id and read data
//   chip_rst_req : request an OTG chip reset pulse
//   busy   : sequencer active or chip reset pending
interface hpi_txn_sequencer_if;
  logic        req0_valid;
  logic        req0_ready;
  logic        req0_write;
  logic [1:0]  req0_addr;
  logic [15:0] req0_wdata;
  logic        req1_valid;
  logic        req1_ready;
  logic        req1_write;
  logic [1:0]  req1_addr;
  logic [15:0] req1_wdata;
  logic        rsp_valid;
  logic        rsp_id;
  logic [15:0] rsp_rdata;
  logic        chip_rst_req;
  logic        busy;

  modport master (
    output req0_valid, req0_write, req0_addr, req0_wdata,
    output req1_valid, req1_write, req1_addr, req1_wdata,
    output chip_rst_req,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_rdata, busy
  );

  modport slave (
    input  req0_valid, req0_write, req0_addr, req0_wdata,
    input  req1_valid, req1_write, req1_addr, req1_wdata,
    input  chip_rst_req,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_rdata, busy
  );
endinterface

// File: rtl/hpi_txn_sequencer.sv
// hpi_txn_sequencer
// Round-robin arbiter and bus sequencer for the CY7C67200 HPI port, plus
// chip reset pulse generation.
//   i_clk        : system clock
//   i_rst_n      : asynchronous active-low reset
//   io_host      : requester/response handshake (slave side)
//   o_otg_cs_n   : HPI chip select, active low
//   o_otg_rd_n   : HPI read strobe, active low
//   o_otg_wr_n   : HPI write strobe, active low
//   o_otg_rst_n  : OTG chip reset, active low
//   o_otg_addr   : HPI register address
//   io_otg_data  : HPI data bus, driven only during a write transaction
//
// state   | meaning
// IDLE    | arbitrate, accept a request, emit completion pulse
// SETUP   | CS/ADDR (and write data) valid ahead of the strobe
// STROBE  | RD_N or WR_N low; read data sampled on the last cycle
// HOLD    | strobe released, CS/ADDR/data held
// CHIPRST | OTG_RST_N low
module hpi_txn_sequencer #(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 4,
  parameter int unsigned HOLD_CYC   = 2,
  parameter int unsigned RST_CYC    = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  hpi_txn_sequencer_if.slave        io_host,
  output logic                      o_otg_cs_n,
  output logic                      o_otg_rd_n,
  output logic                      o_otg_wr_n,
  output logic                      o_otg_rst_n,
  output logic [1:0]                o_otg_addr,
  inout  wire  [15:0]               io_otg_data
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD, ST_CHIPRST
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic        r_write, r_id, r_last_grant, r_rst_pending;
  logic [1:0]  r_addr;
  logic [15:0] r_wdata, r_rdata;
  logic        r_rsp_valid, r_rsp_id;
  logic [15:0] r_rsp_rdata;
  logic        r_cs_n, r_rd_n, r_wr_n, r_otg_rst_n, r_data_oe;

  logic w_grant0, w_grant1, w_can_accept, w_hs0, w_hs1, w_hs;
  logic w_cnt_zero, w_write_nxt, w_txn_nxt;

  // On a tie the requester that did not win last time is granted.
  assign w_grant0     = io_host.req0_valid & (~io_host.req1_valid | r_last_grant);
  assign w_grant1     = io_host.req1_valid & (~io_host.req0_valid | ~r_last_grant);
  assign w_can_accept = i_rst_n & (r_state == ST_IDLE) & ~r_rst_pending;

  assign io_host.req0_ready = w_can_accept & w_grant0;
  assign io_host.req1_ready = w_can_accept & w_grant1;
  assign w_hs0 = io_host.req0_valid & io_host.req0_ready;
  assign w_hs1 = io_host.req1_valid & io_host.req1_ready;
  assign w_hs  = w_hs0 | w_hs1;

  assign w_cnt_zero = (r_cnt == 8'd0);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = w_cnt_zero ? 8'd0 : r_cnt - 8'd1;
    case (r_state)
      ST_IDLE: begin
        // Chip reset outranks requests; ready is already held low while pending.
        if (r_rst_pending) begin
          w_state_nxt = ST_CHIPRST;
          w_cnt_nxt   = 8'(RST_CYC - 1);
        end else if (w_hs) begin
          w_state_nxt = ST_SETUP;
          w_cnt_nxt   = 8'(SETUP_CYC - 1);
        end
      end
      ST_SETUP: if (w_cnt_zero) begin
        w_state_nxt = ST_STROBE;
        w_cnt_nxt   = 8'(STROBE_CYC - 1);
      end
      ST_STROBE: if (w_cnt_zero) begin
        w_state_nxt = ST_HOLD;
        w_cnt_nxt   = 8'(HOLD_CYC - 1);
      end
      ST_HOLD:    if (w_cnt_zero) w_state_nxt = ST_IDLE;
      ST_CHIPRST: if (w_cnt_zero) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Pin drive is derived from the next state so every OTG pin is a flop
  // output that changes on the same edge as the state it belongs to.
  assign w_write_nxt = w_hs ? (w_hs1 ? io_host.req1_write : io_host.req0_write) : r_write;
  assign w_txn_nxt   = (w_state_nxt == ST_SETUP) | (w_state_nxt == ST_STROBE) |
                       (w_state_nxt == ST_HOLD);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_write       <= 1'b0;
      r_id          <= 1'b0;
      r_addr        <= 2'd0;
      r_wdata       <= 16'd0;
      r_rdata       <= 16'd0;
      r_last_grant  <= 1'b1;
      r_rst_pending <= 1'b0;
      r_rsp_valid   <= 1'b0;
      r_rsp_id      <= 1'b0;
      r_rsp_rdata   <= 16'd0;
      r_cs_n        <= 1'b1;
      r_rd_n        <= 1'b1;
      r_wr_n        <= 1'b1;
      r_otg_rst_n   <= 1'b1;
      r_data_oe     <= 1'b0;
    end else begin
      if (w_hs) begin
        r_write      <= w_write_nxt;
        r_id         <= w_hs1;
        r_addr       <= w_hs1 ? io_host.req1_addr  : io_host.req0_addr;
        r_wdata      <= w_hs1 ? io_host.req1_wdata : io_host.req0_wdata;
        r_last_grant <= w_hs1;
      end
      if ((r_state == ST_STROBE) && w_cnt_zero && !r_write) r_rdata <= io_otg_data;

      // A new request in the same cycle as CHIPRST entry is kept, not lost.
      if (io_host.chip_rst_req)
        r_rst_pending <= 1'b1;
      else if ((r_state == ST_IDLE) && (w_state_nxt == ST_CHIPRST))
        r_rst_pending <= 1'b0;

      r_rsp_valid <= (r_state == ST_HOLD) && w_cnt_zero;
      if ((r_state == ST_HOLD) && w_cnt_zero) begin
        r_rsp_id    <= r_id;
        r_rsp_rdata <= r_write ? 16'd0 : r_rdata;
      end

      r_cs_n      <= ~w_txn_nxt;
      r_rd_n      <= ~((w_state_nxt == ST_STROBE) & ~w_write_nxt);
      r_wr_n      <= ~((w_state_nxt == ST_STROBE) & w_write_nxt);
      r_otg_rst_n <= (w_state_nxt != ST_CHIPRST);
      r_data_oe   <= w_txn_nxt & w_write_nxt;
    end
  end

  assign io_host.rsp_valid = r_rsp_valid;
  assign io_host.rsp_id    = r_rsp_id;
  assign io_host.rsp_rdata = r_rsp_rdata;
  assign io_host.busy      = (r_state != ST_IDLE) | r_rst_pending;

  assign o_otg_cs_n  = r_cs_n;
  assign o_otg_rd_n  = r_rd_n;
  assign o_otg_wr_n  = r_wr_n;
  assign o_otg_rst_n = r_otg_rst_n;
  assign o_otg_addr  = r_addr;
  assign io_otg_data = r_data_oe ? r_wdata : 16'hzzzz;

endmodule

// File: doc/hpi_txn_sequencer.md
Name: hpi_txn_sequencer

Overview:
Hardware sequencer and arbiter for the CY7C67200 (EZ-OTG) HPI bus. It accepts single-word read/write requests from two requesters: requester 0 is the NIOS-side HPI PIO path, requester 1 is a hardware USB poller. It grants requesters round-robin and drives OTG_CS_N, OTG_RD_N, OTG_WR_N, OTG_ADDR and OTG_DATA with parameterised setup, strobe and hold timing. It also sequences the chip reset pulse on OTG_RST_N.

Parameters:
SETUP_CYC, 2, cycles CS_N/ADDR (and write data) valid before the strobe; 1..255
STROBE_CYC, 4, cycles RD_N or WR_N held low; 1..255
HOLD_CYC, 2, cycles CS_N/ADDR/data held after the strobe rises; 1..255
RST_CYC, 16, cycles OTG_RST_N held low per chip reset; 1..255

Ports:
Clk  in  1  system clock (50 MHz)
Reset_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has a request
req0_ready  out  1  requester 0 request accepted this cycle
req0_write  in  1  1=write, 0=read
req0_addr  in  2  HPI register address
req0_wdata  in  16  write data
req1_valid, req1_ready, req1_write, req1_addr, req1_wdata  same as requester 0
rsp_valid  out  1  one-cycle completion pulse
rsp_id  out  1  requester that owns the completing transaction
rsp_rdata  out  16  read data; 0 for writes
chip_rst_req  in  1  request a chip reset pulse (level or pulse)
busy  out  1  state != IDLE or reset pending
OTG_DATA  inout  16  HPI data bus
OTG_ADDR  out  2  HPI address
OTG_CS_N, OTG_RD_N, OTG_WR_N, OTG_RST_N  out  1 each  HPI strobes, active low

Behaviour:
- States: IDLE, SETUP, STROBE, HOLD, CHIPRST. An 8-bit down-counter times each state.
- Reset (Reset_n=0, takes effect immediately, asynchronously):
  - state=IDLE
  - OTG_CS_N=OTG_RD_N=OTG_WR_N=OTG_RST_N=1, OTG_ADDR=0, OTG_DATA=Z
  - req*_ready=0, rsp_valid=0, rsp_id=0, rsp_rdata=0, busy=0
  - rst_pending=0, last_grant=1, so requester 0 wins the first tie
- All OTG outputs are registered, and each is a function of the registered state/latched request only.
- Chip reset pending:
  - rst_pending is set on any cycle with chip_rst_req=1 and cleared on entry to CHIPRST.
  - While rst_pending=1, both req*_ready are 0.
- Arbitration (combinational, IDLE only):
  - If exactly one requester is valid, it is granted.
  - If both are valid, the requester != last_grant is granted.
  - reqN_ready = (state==IDLE) & !rst_pending & grantN.
  - Handshake is valid & ready. On handshake: latch write, addr, wdata and id; update last_grant; go to SETUP with counter=SETUP_CYC-1.
- IDLE with rst_pending: go to CHIPRST with counter=RST_CYC-1. Chip reset takes priority over requests.
- SETUP: CS_N=0; ADDR=latched; OTG_DATA=wdata if write else Z; RD_N=WR_N=1. Counter reaches 0 -> STROBE (STROBE_CYC-1).
- STROBE: CS_N=0; RD_N=0 (read) or WR_N=0 (write). For reads, OTG_DATA is sampled into the read register on the last STROBE cycle. Counter reaches 0 -> HOLD (HOLD_CYC-1).
- HOLD: CS_N=0; RD_N=WR_N=1; ADDR held; write data still driven. Counter reaches 0 -> IDLE.
- Completion:
  - In the first IDLE cycle after HOLD: rsp_valid=1 for exactly one cycle, with rsp_id=latched id and rsp_rdata=sampled data (read) or 0 (write).
  - A new request may be accepted in that same cycle.
  - OTG_CS_N is high for at least that one cycle between transactions.
- CHIPRST: OTG_RST_N=0, CS_N/RD_N/WR_N=1, data Z. Counter reaches 0 -> IDLE. No rsp_valid is produced.
- Latency: with the handshake in cycle 0, CS_N is low in cycles 1..SETUP+STROBE+HOLD and rsp_valid is high in cycle SETUP+STROBE+HOLD+1. Defaults give 9.
- chip_rst_req during a transaction: latched; the transaction completes normally; CHIPRST starts the cycle after the rsp_valid cycle.
- Requests are never dropped: a requester's valid/fields must be held stable until its ready.
- OTG_DATA is driven only in SETUP/STROBE/HOLD of a write; it is Z in every other state.

Test Plan:
- Write via requester 0, addr=2, wdata=16'hBEEF, default parameters:
  - OTG_CS_N low in cycles 1–8 and WR_N low in cycles 3–6, with OTG_DATA=BEEF and OTG_ADDR=2 throughout.
  - RD_N stays high.
  - rsp_valid=1 in cycle 9 with rsp_id=0 and rsp_rdata=0.
- Read via requester 1, addr=1; bench drives 16'h1234 while RD_N is low:
  - OTG_DATA is Z on the DUT side.
  - rsp_valid in cycle 9 with rsp_id=1 and rsp_rdata=16'h1234.
- Both requesters held valid continuously for 4 transactions:
  - Grants go 0,1,0,1.
  - Each CS_N low window is 8 cycles, separated by exactly 1 cycle of CS_N high.
- chip_rst_req pulsed during STROBE of a write:
  - The write completes with rsp_valid.
  - Next cycle OTG_RST_N goes low for exactly 16 cycles.
  - req*_ready stays 0 throughout, and a pending request is accepted only after OTG_RST_N returns high.
- Reset_n driven low mid-STROBE of a write:
  - CS_N/WR_N/RST_N go high and OTG_DATA goes Z immediately.
  - No rsp_valid is produced.
  - After release, requester 0 wins a tie.
- Parameters SETUP=HOLD=STROBE=1, back-to-back requester 0 writes: CS_N low 3 cycles, rsp_valid in cycle 4, the next handshake happens in that same cycle.
